word_store_unit: RTL

- Write-back path for the word unit: captures accumulator A (with a target RAM address) on a store instruction and writes it to the shared multicore data RAM.
- Writes go through a request/grant/acknowledge handshake with the RAM arbiter.
- A small posted-write FIFO keeps the core from stalling while the arbiter serves other cores.
- A lookup port forwards pending store data, so loads issued by the same core see their own unretired writes.

---
 rtl/word_store_unit_if.sv | 35 +++
 rtl/word_store_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/word_store_unit_if.sv
// Store-port and RAM-arbiter bus bundle for the word store unit.
// master: the store unit itself (drives the RAM bus and store status).
// slave : the surrounding core/arbiter (drives stores, lookups, grant, ack).
interface word_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              STORE_WE;
  logic [ADDR_W-1:0] STORE_Addr;
  logic [7:0]        STORE_Data;
  logic              STORE_Full;
  logic              STORE_Empty;
  logic              STORE_Overflow;
  logic [ADDR_W-1:0] STORE_LookupAddr;
  logic              STORE_Hit;
  logic [7:0]        STORE_HitData;

  logic              RAM_Req;
  logic              RAM_Gnt;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_Addr;
  logic [7:0]        RAM_WData;
  logic              RAM_Ack;

  modport master (
    input  STORE_WE, STORE_Addr, STORE_Data, STORE_LookupAddr, RAM_Gnt, RAM_Ack,
    output STORE_Full, STORE_Empty, STORE_Overflow, STORE_Hit, STORE_HitData,
           RAM_Req, RAM_WE, RAM_Addr, RAM_WData
  );

  modport slave (
    output STORE_WE, STORE_Addr, STORE_Data, STORE_LookupAddr, RAM_Gnt, RAM_Ack,
    input  STORE_Full, STORE_Empty, STORE_Overflow, STORE_Hit, STORE_HitData,
           RAM_Req, RAM_WE, RAM_Addr, RAM_WData
  );
endinterface

// File: rtl/word_store_unit.sv
// Word store unit: posted-write FIFO between the core's store path and the
// shared data RAM, with store-to-load forwarding of pending entries.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | nothing in flight; leaves as soon as the FIFO is non-empty
// REQ    | requesting the RAM bus, waiting for grant
// WR     | one-cycle write strobe for the head entry
// ACK    | waiting for RAM write completion; retires head on ack
module word_store_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input logic               CLK,
  input logic               CPU_Reset,
  word_store_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WR   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [7:0]        mem_data [DEPTH];

  logic [PTR_W-1:0]  head, tail, head_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              push, pop, drop;
  logic              load_wr;

  logic              full_q, empty_q, overflow_q;
  logic              ram_req_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;

  logic              hit;
  logic [7:0]        hit_data;

  // A store while full is dropped even if the head retires this cycle.
  assign push      = bus.STORE_WE && (count != CNT_FULL);
  assign drop      = bus.STORE_WE && (count == CNT_FULL);
  assign pop       = (state == S_ACK) && bus.RAM_Ack;
  assign head_next = pop ? head + PTR_W'(1) : head;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Next-state logic; load_wr marks edges that present a new head to the RAM.
  always_comb begin
    state_next = state;
    load_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) state_next = S_REQ;
      end
      S_REQ: begin
        if (bus.RAM_Gnt) begin
          state_next = S_WR;
          load_wr    = 1'b1;
        end
      end
      S_WR: begin
        state_next = S_ACK;
      end
      S_ACK: begin
        if (bus.RAM_Ack) begin
          // Entries pushed this same edge are not yet in memory, so only
          // entries already stored behind the head can start a burst.
          if (count > CNT_ONE) begin
            if (bus.RAM_Gnt) begin
              state_next = S_WR;
              load_wr    = 1'b1;
            end else begin
              state_next = S_REQ;
            end
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) state <= S_IDLE;
    else           state <= state_next;
  end

  // FIFO pointers and occupancy; full/empty come from count, never pointers.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      count <= count_next;
      if (push) tail <= tail + PTR_W'(1);
    end
  end

  // Entry storage; contents need no reset because validity comes from count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_addr[tail] <= bus.STORE_Addr;
      mem_data[tail] <= bus.STORE_Data;
    end
  end

  // Registered status flags, overflow is sticky until reset.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      full_q  <= (count_next == CNT_FULL);
      empty_q <= (count_next == '0) && (state_next == S_IDLE);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Registered RAM bus outputs, decoded from the state being entered.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_req_q <= (state_next != S_IDLE);
      ram_we_q  <= (state_next == S_WR);
      if (load_wr) begin
        ram_addr_q  <= mem_addr[head_next];
        ram_wdata_q <= mem_data[head_next];
      end
    end
  end

  // Forwarding: scan oldest to newest so the newest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) &&
          (mem_addr[head + PTR_W'(k)] == bus.STORE_LookupAddr)) begin
        hit      = 1'b1;
        hit_data = mem_data[head + PTR_W'(k)];
      end
    end
  end

  assign bus.STORE_Full     = full_q;
  assign bus.STORE_Empty    = empty_q;
  assign bus.STORE_Overflow = overflow_q;
  assign bus.STORE_Hit      = hit;
  assign bus.STORE_HitData  = hit_data;
  assign bus.RAM_Req        = ram_req_q;
  assign bus.RAM_WE         = ram_we_q;
  assign bus.RAM_Addr       = ram_addr_q;
  assign bus.RAM_WData      = ram_wdata_q;
endmodule
